// File: rtl/output_bank.sv
// Output register bank: captures NUM_CH result words by address and drains
// a complete frame as a valid/ready stream, one channel per beat.
module output_bank #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     wren,
  output logic [NUM_CH*DATA_W-1:0] out,
  output logic [NUM_CH-1:0]        written,
  output logic                     frame_valid,
  input  logic                     drain_start,
  output logic [DATA_W-1:0]        m_data,
  output logic [ADDR_W-1:0]        m_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);

  state_t              state, state_d;
  logic [DATA_W-1:0]   ch [NUM_CH];
  logic [ADDR_W-1:0]   idx;
  logic                wr_ok;
  logic                wr_bad;
  logic                beat;
  logic                last_beat;

  assign wr_ok     = wren && (addr <= LAST_IDX) && (state == IDLE);
  assign wr_bad    = wren && !wr_ok;
  assign beat      = (state == DRAIN) && m_ready;
  assign last_beat = beat && (idx == LAST_IDX);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (drain_start && frame_valid) state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Channel storage; the frame content survives a drain, only the flags clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) ch[k] <= '0;
    end else if (wr_ok) begin
      ch[addr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written <= '0;
      err     <= 1'b0;
    end else begin
      err <= wr_bad;
      if (last_beat)  written       <= '0;
      else if (wr_ok) written[addr] <= 1'b1;
    end
  end

  // Beat index: parked at 0 outside a drain so m_chan/m_data stay defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == IDLE) begin
      idx <= '0;
    end else if (beat) begin
      idx <= last_beat ? '0 : idx + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign out[k*DATA_W +: DATA_W] = ch[k];
  end

  assign frame_valid = (&written) && (state == IDLE);
  assign busy        = (state == DRAIN);
  assign m_valid     = busy;
  assign m_last      = busy && (idx == LAST_IDX);
  assign m_chan      = idx;
  assign m_data      = ch[idx];

endmodule

// File: tb/tb_output_bank.sv
// Directed bench for output_bank (DATA_W=16, NUM_CH=3, ADDR_W=2).
module tb_output_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic [1:0]  addr;
  logic        wren;
  logic [47:0] out;
  logic [2:0]  written;
  logic        frame_valid;
  logic        drain_start;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // {busy, m_valid, m_last, frame_valid, err}
  wire [4:0] st = {busy, m_valid, m_last, frame_valid, err};

  output_bank #(.DATA_W(16), .NUM_CH(3), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .in(in), .addr(addr), .wren(wren),
    .out(out), .written(written), .frame_valid(frame_valid),
    .drain_start(drain_start), .m_data(m_data), .m_chan(m_chan),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    wren = 1'b1;
    addr = 2'd0; in = a; tick();
    addr = 2'd1; in = b; tick();
    addr = 2'd2; in = c; tick();
    wren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wren = 1'b1; addr = 2'd0; in = 16'hAAAA; tick();
    addr = 2'd2; in = 16'h5555; tick();
    wren = 1'b0;
    n_tests++; if (out !== 48'h5555_0000_AAAA) begin n_fail++; $display("FAIL pre_reset_out: got %h want %h", out, 48'h5555_0000_AAAA); end
    rst = 1'b1; tick(); tick();
    n_tests++; if (out !== 48'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
    n_tests++; if (written !== 3'b000) begin n_fail++; $display("FAIL reset_written: got %b want 000", written); end
    n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL reset_status: got %b want 00000", st); end
    n_tests++; if (m_chan !== 2'd0) begin n_fail++; $display("FAIL reset_m_chan: got %0d want 0", m_chan); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    wren = 1'b1; addr = 2'd0; in = 16'h1111; tick();
    n_tests++; if (written !== 3'b001) begin n_fail++; $display("FAIL fill_written0: got %b want 001", written); end
    addr = 2'd1; in = 16'h2222; tick();
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL fill_fv_early: got %b want 0", frame_valid); end
    addr = 2'd2; in = 16'h3333; tick();
    wren = 1'b0;
    n_tests++; if (out !== 48'h3333_2222_1111) begin n_fail++; $display("FAIL fill_out: got %h want %h", out, 48'h3333_2222_1111); end
    n_tests++; if (written !== 3'b111) begin n_fail++; $display("FAIL fill_written: got %b want 111", written); end
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL fill_fv: got %b want 1", frame_valid); end
  endtask

  task automatic test_bad_addr();
    wren = 1'b1; addr = 2'd3; in = 16'hDEAD; tick();
    wren = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL badaddr_err: got %b want 1", err); end
    n_tests++; if (out !== 48'h3333_2222_1111) begin n_fail++; $display("FAIL badaddr_out: got %h want %h", out, 48'h3333_2222_1111); end
    n_tests++; if (written !== 3'b111) begin n_fail++; $display("FAIL badaddr_written: got %b want 111", written); end
    tick();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL badaddr_err_clear: got %b want 0", err); end
  endtask

  task automatic test_drain_backpressure();
    m_ready = 1'b0;
    drain_start = 1'b1; tick();
    drain_start = 1'b0;
    n_tests++; if (st !== 5'b11000) begin n_fail++; $display("FAIL drain_status0: got %b want 11000", st); end
    n_tests++; if ({m_chan, m_data} !== {2'd0, 16'h1111}) begin n_fail++; $display("FAIL drain_beat0: got %0d/%h want 0/1111", m_chan, m_data); end
    m_ready = 1'b1; tick();
    n_tests++; if ({m_chan, m_data} !== {2'd1, 16'h2222}) begin n_fail++; $display("FAIL drain_beat1: got %0d/%h want 1/2222", m_chan, m_data); end
    m_ready = 1'b0; tick();
    n_tests++; if ({m_chan, m_data, m_valid} !== {2'd1, 16'h2222, 1'b1}) begin n_fail++; $display("FAIL drain_stall1: got %0d/%h/%b want 1/2222/1", m_chan, m_data, m_valid); end
    tick();
    n_tests++; if ({m_chan, m_data, m_valid} !== {2'd1, 16'h2222, 1'b1}) begin n_fail++; $display("FAIL drain_stall2: got %0d/%h/%b want 1/2222/1", m_chan, m_data, m_valid); end
    m_ready = 1'b1; tick();
    n_tests++; if ({m_chan, m_data} !== {2'd2, 16'h3333}) begin n_fail++; $display("FAIL drain_beat2: got %0d/%h want 2/3333", m_chan, m_data); end
    n_tests++; if (st !== 5'b11100) begin n_fail++; $display("FAIL drain_last_status: got %b want 11100", st); end
    tick();
    m_ready = 1'b0;
    n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL drain_done_status: got %b want 00000", st); end
    n_tests++; if (written !== 3'b000) begin n_fail++; $display("FAIL drain_done_written: got %b want 000", written); end
    n_tests++; if (out !== 48'h3333_2222_1111) begin n_fail++; $display("FAIL drain_done_out: got %h want %h", out, 48'h3333_2222_1111); end
  endtask

  task automatic test_write_during_drain();
    fill(16'h1111, 16'h2222, 16'h3333);
    m_ready = 1'b0;
    drain_start = 1'b1; tick();
    drain_start = 1'b0;
    wren = 1'b1; addr = 2'd1; in = 16'hBEEF; tick();
    wren = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wdrain_err: got %b want 1", err); end
    n_tests++; if (out[31:16] !== 16'h2222) begin n_fail++; $display("FAIL wdrain_ch1: got %h want 2222", out[31:16]); end
    n_tests++; if ({m_chan, m_data} !== {2'd0, 16'h1111}) begin n_fail++; $display("FAIL wdrain_beat0: got %0d/%h want 0/1111", m_chan, m_data); end
    m_ready = 1'b1; tick();
    n_tests++; if ({err, m_data} !== {1'b0, 16'h2222}) begin n_fail++; $display("FAIL wdrain_beat1: got %b/%h want 0/2222", err, m_data); end
    tick();
    n_tests++; if (m_data !== 16'h3333) begin n_fail++; $display("FAIL wdrain_beat2: got %h want 3333", m_data); end
    tick();
    m_ready = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wdrain_done: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_drain();
    fill(16'h1111, 16'h2222, 16'h3333);
    drain_start = 1'b1; tick();
    drain_start = 1'b0;
    m_ready = 1'b1; tick();
    n_tests++; if (m_chan !== 2'd1) begin n_fail++; $display("FAIL middrain_chan: got %0d want 1", m_chan); end
    rst = 1'b1; m_ready = 1'b0; tick();
    n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL middrain_status: got %b want 00000", st); end
    n_tests++; if ({out, written} !== {48'h0, 3'b000}) begin n_fail++; $display("FAIL middrain_regs: got %h/%b want 0/000", out, written); end
    n_tests++; if ({m_chan, m_data} !== {2'd0, 16'h0}) begin n_fail++; $display("FAIL middrain_stream: got %0d/%h want 0/0000", m_chan, m_data); end
    rst = 1'b0;
  endtask

  task automatic test_corner();
    drain_start = 1'b1; tick();
    drain_start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL corner_empty_drain: got %b want 0", busy); end
    wren = 1'b1;
    addr = 2'd0; in = 16'hAAAA; tick();
    addr = 2'd1; in = 16'hBBBB; tick();
    addr = 2'd2; in = 16'hCCCC; drain_start = 1'b1; tick();
    wren = 1'b0; drain_start = 1'b0;
    n_tests++; if ({busy, frame_valid, written} !== {1'b0, 1'b1, 3'b111}) begin n_fail++; $display("FAIL corner_completing_write: got %b/%b/%b want 0/1/111", busy, frame_valid, written); end
    wren = 1'b1; addr = 2'd1; in = 16'h7777; drain_start = 1'b1; tick();
    wren = 1'b0;
    n_tests++; if ({busy, err, out[31:16]} !== {1'b1, 1'b0, 16'h7777}) begin n_fail++; $display("FAIL corner_same_edge: got %b/%b/%h want 1/0/7777", busy, err, out[31:16]); end
    m_ready = 1'b1;
    n_tests++; if ({m_chan, m_data} !== {2'd0, 16'hAAAA}) begin n_fail++; $display("FAIL b2b_beat0: got %0d/%h want 0/aaaa", m_chan, m_data); end
    tick();
    n_tests++; if ({m_chan, m_data, m_last} !== {2'd1, 16'h7777, 1'b0}) begin n_fail++; $display("FAIL b2b_beat1: got %0d/%h/%b want 1/7777/0", m_chan, m_data, m_last); end
    tick();
    n_tests++; if ({m_chan, m_data, m_last} !== {2'd2, 16'hCCCC, 1'b1}) begin n_fail++; $display("FAIL b2b_beat2: got %0d/%h/%b want 2/cccc/1", m_chan, m_data, m_last); end
    tick();
    drain_start = 1'b0; m_ready = 1'b0;
    n_tests++; if ({st, written} !== {5'b00000, 3'b000}) begin n_fail++; $display("FAIL b2b_done: got %b/%b want 00000/000", st, written); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart: got %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; in = '0; addr = '0; wren = 1'b0; drain_start = 1'b0; m_ready = 1'b0;
    tick(); tick();
    test_reset();
    test_fill();
    test_bad_addr();
    test_drain_backpressure();
    test_write_during_drain();
    test_reset_mid_drain();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_bank.md
Name: output_bank

Overview:
- Parametrised output register bank for the DNN datapath; successor to the fixed 3×16-bit output block.
- Captures NUM_CH result words written by address. Tracks which channels hold fresh data and flags a complete frame.
- Drains a complete frame as a valid/ready stream, one channel per beat, to the downstream host/serialiser.
- Flags illegal writes: out-of-range address, or any write during a drain.

Parameters:
- DATA_W, 16, width of each channel word.
- NUM_CH, 3, number of output channels; must be ≥2.
- ADDR_W, 2, address width; 2**ADDR_W ≥ NUM_CH required.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in  input  DATA_W  write data.
- addr  input  ADDR_W  channel index for the write.
- wren  input  1  write enable.
- out  output  NUM_CH*DATA_W  all channel registers; channel k occupies bits [k*DATA_W +: DATA_W].
- written  output  NUM_CH  per-channel fresh flag.
- frame_valid  output  1  all channels written, drain not yet started.
- drain_start  input  1  request to stream the current frame.
- m_data  output  DATA_W  stream data.
- m_chan  output  ADDR_W  channel index of the current beat.
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- m_last  output  1  marks the final beat of a frame.
- busy  output  1  FSM is in DRAIN.
- err  output  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (rst high at posedge): out, written and m_chan go to 0. frame_valid, m_valid, m_last, busy and err go to 0. FSM goes to IDLE. rst overrides every other input.
- Write accepted when wren=1, addr<NUM_CH and FSM=IDLE.
  - Channel addr takes in at the edge; written[addr] is set.
  - Rewriting an already-written channel overwrites it; the flag stays 1.
- Write rejected when wren=1 and either addr≥NUM_CH or FSM=DRAIN.
  - No register changes.
  - err=1 for exactly the following cycle.
- frame_valid = (written == all ones) && FSM=IDLE. Combinational from registered state, so it rises the cycle after the last required write.
- FSM states: IDLE, DRAIN.
- IDLE→DRAIN: drain_start=1 while frame_valid=1.
  - Samples pre-edge state, so a write at the same edge as drain_start does not by itself enable the drain.
  - That write is still accepted, because FSM was IDLE.
  - On entry, the index register is set to 0.
  - drain_start with frame_valid=0 is ignored.
- In DRAIN:
  - m_valid=1, m_chan=index, m_data = channel[index].
  - m_last=1 when index==NUM_CH-1.
  - busy=1.
- Beat transfers on m_valid && m_ready at a posedge.
  - Not last: index increments.
  - Last: FSM→IDLE and written clears to 0. out registers keep their values.
- m_ready low: index, m_data and m_chan hold stable (AXI-style; no combinational path from m_ready to m_valid).
- drain_start during DRAIN is ignored.
- Latency:
  - Write→out visible: 1 cycle.
  - drain_start→first m_valid: 1 cycle.
  - Back-to-back beats when m_ready is held high: a full frame takes NUM_CH cycles.
- Reset mid-drain aborts the frame: FSM→IDLE and every output returns to its reset value.
- IDLE outputs: m_valid, m_last and busy are 0. m_data and m_chan are don't-care, but must not toggle X.

Test Plan:
- Reset: drive rst=1 for 2 cycles after random writes → out=0, written=000, frame_valid=0, m_valid=0, err=0.
- Fill frame: write 0x1111@0, 0x2222@1, 0x3333@2 → out={0x3333,0x2222,0x1111}, written=111, frame_valid=1 on the cycle after the third write.
- Bad address: wren with addr=3, in=0xDEAD (NUM_CH=3) → err pulses exactly 1 cycle, out and written unchanged.
- Drain with backpressure: drain_start, then m_ready pattern 1,0,0,1,1 → beats (chan0,0x1111), (chan1,0x2222) held 2 stall cycles, then (chan2,0x3333) with m_last=1; the cycle after the last beat shows busy=0, written=000, frame_valid=0, out unchanged.
- Write during drain: wren addr=1 in=0xBEEF while busy → err pulse, channel1 stays 0x2222, stream data unaffected.
- Reset mid-drain plus corner cases: assert rst after the first beat → m_valid=0, busy=0, all outputs 0. Then refill the frame and check:
  - drain_start with frame_valid=0 is ignored.
  - A write at the same edge as drain_start on a full frame is accepted and the drain starts.
